// File: rtl/ahb_lite_slave_mem_if.sv
// AHB-Lite bus bundle between a master (or bus mux) and the ahb_lite_slave_mem responder.
// HREADY is the mux-level ready fed back to the slave; HREADYOUT is the slave's own ready.
interface ahb_lite_slave_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic              HREADYOUT;
    logic              HRESP;
    logic [DATA_W-1:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite SRAM responder: pipelined address/data phases, byte-lane writes, two-cycle ERROR.
// Define AHB_SLV_WAIT_EN to insert WAIT_CYCLES wait states before every OKAY data phase.
module ahb_lite_slave_mem #(
    parameter int              ADDR_W      = 32,
    parameter int              DATA_W      = 32,
    parameter int              MEM_DEPTH   = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              WAIT_CYCLES = 1
) (
    input  logic               HCLK,
    input  logic               HRESET,
    ahb_lite_slave_mem_if.slave bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int OFF_W = IDX_W + 2;
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(4 * MEM_DEPTH);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 0..15");
    end

`ifdef AHB_SLV_WAIT_EN
    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
`else
    localparam bit ZERO_WAIT = 1'b1;
`endif

    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

    state_t state, state_nxt;

    logic [OFF_W-1:0]  off_q;
    logic              wr_q;
    logic [2:0]        size_q;
    logic              err_q;

    logic [ADDR_W-1:0] offset;
    logic              addr_err;
    logic              accept;
    logic              ready, resp;

    assign offset   = bus.HADDR - BASE_ADDR;
    assign addr_err = (bus.HADDR < BASE_ADDR) || (offset >= SPAN) || (bus.HSIZE > 3'd2)
                   || (bus.HSIZE == 3'd1 && bus.HADDR[0])
                   || (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00);

    // Only phases that drive HREADYOUT=1 can close the previous transfer and take a new one.
    assign accept = bus.HSEL && bus.HREADY && bus.HTRANS[1]
                 && (state == IDLE || state == DATA || state == ERR2);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state  <= IDLE;
            off_q  <= '0;
            wr_q   <= 1'b0;
            size_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                off_q  <= offset[OFF_W-1:0];
                wr_q   <= bus.HWRITE;
                size_q <= bus.HSIZE;
                err_q  <= addr_err;
            end
        end
    end

`ifdef AHB_SLV_WAIT_EN
    logic [3:0] wcnt;

    always_ff @(posedge HCLK) begin
        if (HRESET)                       wcnt <= '0;
        else if (accept && !addr_err)     wcnt <= 4'(WAIT_CYCLES);
        else if (state == WAIT && wcnt != 4'd0) wcnt <= wcnt - 4'd1;
    end
`endif

    always_comb begin
        state_nxt = state;
        ready     = 1'b1;
        resp      = 1'b0;
        case (state)
            IDLE, DATA, ERR2: begin
                resp      = (state == ERR2);
                state_nxt = IDLE;
                if (accept) begin
                    if (addr_err)       state_nxt = ERR1;
                    else if (ZERO_WAIT) state_nxt = DATA;
                    else                state_nxt = WAIT;
                end
            end
`ifdef AHB_SLV_WAIT_EN
            WAIT: begin
                ready = 1'b0;
                if (wcnt == 4'd1) state_nxt = DATA;
            end
`endif
            ERR1: begin
                ready     = 1'b0;
                resp      = 1'b1;
                state_nxt = ERR2;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.HREADYOUT = ready;
    assign bus.HRESP     = resp;

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [3:0]        lanes;
    logic [IDX_W-1:0]  idx;
    logic              rd_now;
    logic [DATA_W-1:0] rd_hold;

    assign idx    = off_q[OFF_W-1:2];
    assign rd_now = (state == DATA) && !wr_q;

    always_comb begin
        case (size_q)
            3'd0:    lanes = 4'b0001 << off_q[1:0];
            3'd1:    lanes = off_q[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    // Gated by HRESET so a reset during the data phase drops the pending write.
    always_ff @(posedge HCLK) begin
        if (!HRESET && state == DATA && wr_q && !err_q) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes[b]) mem[idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET)      rd_hold <= '0;
        else if (rd_now) rd_hold <= mem[idx];
    end

    assign bus.HRDATA = rd_now ? mem[idx] : rd_hold;
endmodule
